// File: rtl/hamming_pkg.sv
// Shared types and the SECDED Hamming(8,4) encoder used by hamming_enc_arbiter.
package hamming_pkg;

  localparam int unsigned CODE_W  = 8;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned ID_MAXW = 3;  // enough for up to 8 requesters

  typedef struct packed {
    logic [CODE_W-1:0]  code;
    logic [ID_MAXW-1:0] id;
  } entry;

  function automatic logic [CODE_W-1:0] ham84_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c[7] = d[3] ^ d[2] ^ d[0];
    c[6] = d[3] ^ d[1] ^ d[0];
    c[5] = d[3];
    c[4] = d[2] ^ d[1] ^ d[0];
    c[3] = d[2];
    c[2] = d[1];
    c[1] = d[0];
    c[0] = ^c[7:1];
    return c;
  endfunction

endpackage

// File: rtl/hamming_enc_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the pointer.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] sel;
  logic           found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    grant = '0;
    // First pass covers [ptr, NREQ), second pass wraps to [0, ptr).
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDW'(i) >= ptr_q)) begin
        found = 1'b1;
        sel   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        sel   = IDW'(i);
      end
    end
    ptr_d = ptr_q;
    if (enable && found) begin
      grant[sel] = 1'b1;
      ptr_d      = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hamming_enc_arbiter.sv
// NREQ nibble producers share one Hamming(8,4) encoder feeding an output FIFO.
// Optional HAM_ERR_INJ_EN adds a one-shot single-bit error injector on the push path.
module hamming_enc_arbiter
  import hamming_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*4-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_code,
  output logic [IDW-1:0]           out_id,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef HAM_ERR_INJ_EN
  ,
  input  logic                     inj_valid,
  input  logic [2:0]               inj_bit
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  entry            mem_q [DEPTH];
  entry            head;
  entry            wr_entry;
  logic            push_ok, push, pop;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic [3:0]      nibble;
  logic [7:0]      wr_code;
  logic            unused_head_id;

  // No push while full, even if the head pops this cycle; never grant during reset.
  assign push_ok = (count_q < CW'(DEPTH));

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .enable (push_ok & rst_n),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign push      = |grant;
  assign pop       = out_valid & out_ready;

  always_comb begin
    gnt_id = '0;
    nibble = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_id = IDW'(i);
        nibble = req_data[i*4 +: 4];
      end
    end
  end

`ifdef HAM_ERR_INJ_EN
  logic       arm_q, arm_d, flip;
  logic [2:0] inj_bit_q, inj_bit_d, flip_bit;

  // A fresh arm applies to a push in the same cycle.
  always_comb begin
    flip      = arm_q | inj_valid;
    flip_bit  = inj_valid ? inj_bit : inj_bit_q;
    arm_d     = flip & ~push;
    inj_bit_d = flip_bit;
    wr_code   = ham84_encode(nibble) ^ (flip ? (8'h01 << flip_bit) : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q     <= 1'b0;
      inj_bit_q <= '0;
    end else begin
      arm_q     <= arm_d;
      inj_bit_q <= inj_bit_d;
    end
  end
`else
  assign wr_code = ham84_encode(nibble);
`endif

  always_comb begin
    wr_entry      = '0;
    wr_entry.code = wr_code;
    wr_entry.id   = ID_MAXW'(gnt_id);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign out_valid      = (count_q != '0);
  assign out_code       = head.code;
  assign out_id         = head.id[IDW-1:0];
  assign fifo_count     = count_q;
  assign unused_head_id = ^head.id;

endmodule
